// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter for a shared sample FIFO.
// N_SRC producers compete for the single FIFO write port. One source is
// granted at a time for a burst of up to BURST_LEN beats; accepted samples
// are forwarded one cycle later on fifo_val/fifo_data. A credit counter
// mirrors the free FIFO space so the FIFO can never be overwritten.
//
// Handshake: a beat from source i is transferred on a rising clk edge where
// src_val[i] && src_ready[i]. src_val must not depend on src_ready.
// src_ready is combinational from registered state only: it is high for
// the granted source while in BURST and at least one credit is available.
// fifo_val is a one-cycle write strobe; the FIFO has no back-pressure
// other than the credits returned through credit_ret.
module fifo_wr_arb #(
    parameter int N_SRC     = 4,
    parameter int data_wdt  = 16,
    parameter int fifo_deth = 16,
    parameter int BURST_LEN = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_SRC-1:0]                  src_val,
    input  logic [N_SRC*data_wdt-1:0]         src_data,
    output logic [N_SRC-1:0]                  src_ready,
    input  logic                              credit_ret,
    output logic                              fifo_val,
    output logic signed [data_wdt-1:0]        fifo_data,
    output logic [$clog2(N_SRC)-1:0]          grant_id,
    output logic                              busy,
    output logic [$clog2(fifo_deth):0]        credits
);

    localparam int GW = $clog2(N_SRC);
    localparam int CW = $clog2(fifo_deth) + 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state;
    logic [BW-1:0]   beat_cnt;

    logic            have_credit;
    logic            cur_val;
    logic            accept;
    logic            pick_found;
    logic [GW-1:0]   pick_id;

    assign have_credit = (credits != '0);
    assign cur_val     = src_val[grant_id];
    assign accept      = (state == BURST) && cur_val && have_credit;

    // Round-robin search: first requester after the last granted source.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = grant_id;
        for (int k = 1; k <= N_SRC; k++) begin
            if (!pick_found && src_val[(int'(grant_id) + k) % N_SRC]) begin
                pick_found = 1'b1;
                pick_id    = GW'((int'(grant_id) + k) % N_SRC);
            end
        end
    end

    // Only the granted source may transfer, and only while credits remain.
    always_comb begin
        src_ready = '0;
        if (state == BURST && have_credit) begin
            src_ready[grant_id] = 1'b1;
        end
    end

    // Grant FSM: one arbitration cycle in IDLE, then a burst in BURST.
    // With no credits the burst stalls rather than releasing the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= GW'(N_SRC - 1);
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found && have_credit) begin
                        grant_id <= pick_id;
                        beat_cnt <= '0;
                        state    <= BURST;
                        busy     <= 1'b1;
                    end
                end
                BURST: begin
                    if (have_credit) begin
                        if (!cur_val) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            if (beat_cnt == BW'(BURST_LEN - 1)) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Forward each accepted beat one cycle later; data holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_val  <= 1'b0;
            fifo_data <= '0;
        end else begin
            fifo_val <= accept;
            if (accept) begin
                fifo_data <= src_data[grant_id*data_wdt +: data_wdt];
            end
        end
    end

    // Free-slot counter: spend on accept, refund on credit_ret, saturate at depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CW'(fifo_deth);
        end else begin
            case ({accept, credit_ret})
                2'b10: credits <= credits - 1'b1;
                2'b01: begin
                    if (credits != CW'(fifo_deth)) begin
                        credits <= credits + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed scenarios for the round-robin FIFO write arbiter.
// Producers advance their sample index whenever a beat is transferred; the
// expected FIFO stream is queued up front and popped on every fifo_val.
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int D  = 16;
    localparam int BL = 4;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     src_val;
    logic [N*W-1:0]   src_data;
    logic [N-1:0]     src_ready;
    logic             credit_ret;
    logic             fifo_val;
    logic signed [W-1:0] fifo_data;
    logic [1:0]       grant_id;
    logic             busy;
    logic [4:0]       credits;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .N_SRC(N), .data_wdt(W), .fifo_deth(D), .BURST_LEN(BL)
    ) dut (
        .clk(clk), .rst(rst),
        .src_val(src_val), .src_data(src_data), .src_ready(src_ready),
        .credit_ret(credit_ret),
        .fifo_val(fifo_val), .fifo_data(fifo_data),
        .grant_id(grant_id), .busy(busy), .credits(credits)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           beats;
    logic [31:0]  hist;
    int           ret_mode;
    logic [N-1:0] en;
    int           cnt[N];
    int           lim[N];
    logic [N-1:0] acc_pre;

    // Handshakes as seen just before each edge.
    always @(posedge clk) acc_pre <= src_val & src_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] data_of(input int i, input int k);
        if (i == 3) return W'(-(k + 1));
        return W'(i * 256 + k + 1);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            src_val[i]          = en[i] && (cnt[i] < lim[i]);
            src_data[i*W +: W]  = data_of(i, cnt[i]);
        end
    endtask

    // One clock: advance producers, score fifo output, refresh inputs.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc_pre[i]) cnt[i]++;
        hist = {hist[30:0], fifo_val};
        if (fifo_val) begin
            beats++;
            if (exp_q.size() == 0) begin
                check("spurious_fifo_val", {31'b0, fifo_val}, 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("fifo_data", {16'b0, fifo_data}, {16'b0, e});
            end
        end
        if (ret_mode == 1) credit_ret = fifo_val;
        else if (ret_mode == 2) credit_ret = busy;
        drive_src();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        credit_ret = 1'b0;
        ret_mode   = 0;
        en         = '0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            lim[i] = 0;
        end
        drive_src();
        step();
        step();
        rst   = 1'b0;
        hist  = '0;
        beats = 0;
    endtask

    task automatic push_src(input int i, input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) exp_q.push_back(data_of(i, k));
    endtask

    // Bound the whole run.
    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [25:0] e2;

        // ---- reset values ----
        do_reset();
        check("rst_fifo_val", {31'b0, fifo_val}, 32'd0);
        check("rst_fifo_data", {16'b0, fifo_data}, 32'd0);
        check("rst_src_ready", {28'b0, src_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_grant_id", {30'b0, grant_id}, 32'd3);
        check("rst_credits", {27'b0, credits}, 32'd16);

        // ---- single source, five samples ----
        en = 4'b0001; lim[0] = 5; drive_src();
        push_src(0, 0, 5);
        step();
        check("s1_busy", {31'b0, busy}, 32'd1);
        check("s1_grant", {30'b0, grant_id}, 32'd0);
        check("s1_ready", {28'b0, src_ready}, 32'd1);
        repeat (8) step();
        check("s1_val_pattern", {23'b0, hist[8:0]}, {23'b0, 9'b011110100});
        check("s1_credits", {27'b0, credits}, 32'd11);
        check("s1_drained", exp_q.size(), 32'd0);

        // ---- all four sources, reader returning credits ----
        do_reset();
        en = 4'b1111; lim[0] = 8; lim[1] = 4; lim[2] = 4; lim[3] = 4;
        ret_mode = 1; drive_src();
        push_src(0, 0, 4); push_src(1, 0, 4); push_src(2, 0, 4);
        push_src(3, 0, 4); push_src(0, 4, 4);
        step();
        check("s2_first_grant", {30'b0, grant_id}, 32'd0);
        repeat (27) step();
        e2 = '0;
        for (int s = 1; s <= 26; s++) e2 = {e2[24:0], (s <= 25) && ((s % 5) != 1)};
        check("s2_val_pattern", {6'b0, hist[27:2]}, {6'b0, e2});
        check("s2_credits", {27'b0, credits}, 32'd16);
        check("s2_drained", exp_q.size(), 32'd0);

        // ---- credit exhaustion mid-burst ----
        do_reset();
        en = 4'b0010; lim[1] = 2; drive_src();
        push_src(1, 0, 2); push_src(0, 0, 15);
        step();
        check("s3_grant1", {30'b0, grant_id}, 32'd1);
        en[0] = 1'b1; lim[0] = 30; drive_src();
        for (int g = 0; g < 80 && beats < 16; g++) step();
        check("s3_reach16", beats, 32'd16);
        repeat (4) step();
        check("s3_beats_stalled", beats, 32'd16);
        check("s3_credits0", {27'b0, credits}, 32'd0);
        check("s3_ready0", {28'b0, src_ready}, 32'd0);
        check("s3_busy_stall", {31'b0, busy}, 32'd1);
        check("s3_grant0", {30'b0, grant_id}, 32'd0);
        credit_ret = 1'b1;
        step();
        credit_ret = 1'b0;
        repeat (4) step();
        check("s3_one_more", beats, 32'd17);
        check("s3_credits_back0", {27'b0, credits}, 32'd0);
        check("s3_busy_still", {31'b0, busy}, 32'd1);
        check("s3_drained", exp_q.size(), 32'd0);

        // ---- accept and credit_ret together, 20 beats ----
        do_reset();
        en = 4'b0001; lim[0] = 20; ret_mode = 2; drive_src();
        push_src(0, 0, 20);
        for (int s = 0; s < 26; s++) begin
            step();
            check("s4_credits_const", {27'b0, credits}, 32'd16);
        end
        check("s4_beats", beats, 32'd20);
        check("s4_drained", exp_q.size(), 32'd0);

        // ---- early release hands over to the next requester ----
        do_reset();
        en = 4'b1100; lim[2] = 2; lim[3] = 4; drive_src();
        push_src(2, 0, 2); push_src(3, 0, 4); push_src(0, 0, 4);
        step();
        check("s5_grant2", {30'b0, grant_id}, 32'd2);
        en[0] = 1'b1; lim[0] = 4; drive_src();
        repeat (3) step();
        check("s5_released", {31'b0, busy}, 32'd0);
        step();
        check("s5_grant3", {30'b0, grant_id}, 32'd3);
        check("s5_busy3", {31'b0, busy}, 32'd1);
        for (int g = 0; g < 40 && exp_q.size() > 0; g++) step();
        repeat (3) step();
        check("s5_drained", exp_q.size(), 32'd0);
        check("s5_beats", beats, 32'd10);

        // ---- reset during beat 2 of source 1 ----
        do_reset();
        en = 4'b0010; lim[1] = 10; drive_src();
        push_src(1, 0, 1);
        step();
        step();
        rst = 1'b1;
        step();
        check("s6_fifo_val", {31'b0, fifo_val}, 32'd0);
        check("s6_credits", {27'b0, credits}, 32'd16);
        check("s6_grant", {30'b0, grant_id}, 32'd3);
        check("s6_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        en = 4'b1111;
        for (int i = 0; i < N; i++) lim[i] = 10;
        drive_src();
        step();
        check("s6_regrant0", {30'b0, grant_id}, 32'd0);
        check("s6_rebusy", {31'b0, busy}, 32'd1);
        check("s6_no_beat", {31'b0, fifo_val}, 32'd0);
        do_reset();
        check("s6_drained", exp_q.size(), 32'd0);
        check("s6_beats", beats, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
